// File: rtl/uart_rx_unit_pkg.sv
// uart_rx_unit_pkg: constants shared by the MiniUart receive unit.
//   rx_state_t         - receive FSM state encodings
//   DEFAULT_OVERSAMPLE - en_rx ticks per bit unless overridden
//   FRAME_BITS         - data bits per frame
package uart_rx_unit_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int FRAME_BITS         = 8;

endpackage

// File: rtl/uart_rx_unit_if.sv
// uart_rx_unit_if: bus-side register interface of the receive unit.
//   rd    - read acknowledge pulse from the bus host
//   d_out - last received byte
//   rs    - unread byte present
//   fe    - stop bit of the last byte sampled as 0
//   oe    - a byte completed while rs was still set
// master: bus host side. slave: receive unit side.
interface uart_rx_unit_if;
  logic       rd;
  logic [7:0] d_out;
  logic       rs;
  logic       fe;
  logic       oe;

  modport master (output rd, input d_out, rs, fe, oe);
  modport slave  (input rd, output d_out, rs, fe, oe);
endinterface

// File: rtl/uart_rx_unit_rx_sync.sv
// rx_sync: two-flop synchroniser for the asynchronous serial input.
//   clk - system clock
//   rst - synchronous active-high reset; both flops reset to the idle level 1
//   d   - asynchronous input
//   q   - synchronised output
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: MiniUart receiver. Oversamples rxd on en_rx, finds the start
// bit, samples 8 data bits LSB first at mid-bit, checks the stop bit and
// presents the byte with rs/fe/oe flags on the bus interface.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   rxd   - asynchronous serial input, idle 1
//   en_rx - one-cycle tick at OVERSAMPLE x baud
//   bus   - register interface (rd in; d_out, rs, fe, oe out)
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit, rejecting glitches
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | waiting for mid stop bit, then delivering the byte
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  input  logic           en_rx,
  uart_rx_unit_if.slave  bus
);
  localparam logic [4:0] OS_HALF  = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] OS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(FRAME_BITS - 1);

  rx_state_t  state, state_nxt;
  logic [4:0] cnt_os, cnt_os_nxt;
  logic [2:0] cnt_bit, cnt_bit_nxt;
  logic [7:0] sh, sh_nxt;
  logic       done;
  logic       rxd_s;
  logic [1:0] fill;
  logic       armed;
  logic [7:0] d_out_q;
  logic       rs_q, fe_q, oe_q;

  rx_sync u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));

  // The synchroniser resets to 1, which says nothing about the real line.
  // After reset a start edge is accepted only once the real line has been
  // seen at 1, so the tail of a frame cut by reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && rxd_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt_os  <= '0;
      cnt_bit <= '0;
      sh      <= '0;
    end else begin
      state   <= state_nxt;
      cnt_os  <= cnt_os_nxt;
      cnt_bit <= cnt_bit_nxt;
      sh      <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_os_nxt  = cnt_os;
    cnt_bit_nxt = cnt_bit;
    sh_nxt      = sh;
    done        = 1'b0;
    if (en_rx) begin
      unique case (state)
        RX_IDLE: begin
          if (armed && !rxd_s) begin
            state_nxt  = RX_START;
            cnt_os_nxt = '0;
          end
        end
        RX_START: begin
          if (cnt_os == OS_HALF) begin
            if (!rxd_s) begin
              state_nxt   = RX_DATA;
              cnt_os_nxt  = '0;
              cnt_bit_nxt = '0;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            cnt_os_nxt = cnt_os + 5'd1;
          end
        end
        RX_DATA: begin
          if (cnt_os == OS_LAST) begin
            sh_nxt     = {rxd_s, sh[7:1]};
            cnt_os_nxt = '0;
            if (cnt_bit == BIT_LAST) state_nxt = RX_STOP;
            else cnt_bit_nxt = cnt_bit + 3'd1;
          end else begin
            cnt_os_nxt = cnt_os + 5'd1;
          end
        end
        RX_STOP: begin
          // Leaving at mid-stop lets a start edge in the second half through.
          if (cnt_os == OS_LAST) begin
            done      = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            cnt_os_nxt = cnt_os + 5'd1;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // Completion takes priority over a coincident read acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= '0;
      rs_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else if (done) begin
      d_out_q <= sh;
      rs_q    <= 1'b1;
      fe_q    <= ~rxd_s;
      oe_q    <= rs_q & ~bus.rd;
    end else if (bus.rd) begin
      rs_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.rs    = rs_q;
  assign bus.fe    = fe_q;
  assign bus.oe    = oe_q;
endmodule
